// File: rtl/sc_reg_lfsr_pkg.sv
// sc_reg_lfsr shared types and constants.
// FSM/mode encodings plus default LFSR constants.
package sc_reg_lfsr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } lfsr_state_e;

  typedef enum logic {
    MODE_FIB = 1'b0,
    MODE_GAL = 1'b1
  } lfsr_mode_e;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [7:0]  POLY_W8  = 8'h1D;
  localparam logic [7:0]  SEED_W8  = 8'h01;

  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [15:0] POLY_W16 = 16'h100B;
  localparam logic [15:0] SEED_W16 = 16'h0001;

  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;
  localparam logic [31:0] POLY_W32 = 32'h0000_00C5;
  localparam logic [31:0] SEED_W32 = 32'h0000_0001;

endpackage

// File: rtl/sc_lfsr_next.sv
// sc_lfsr_next: one LFSR step, Fibonacci or Galois.
// Pure combinational next-state function.
module sc_lfsr_next
  import sc_reg_lfsr_pkg::*;
#(
  parameter int         W    = 8,
  parameter logic [W-1:0] TAPS = 8'hB8,
  parameter logic [W-1:0] POLY = 8'h1D
) (
  input  logic [W-1:0] state_i,
  input  lfsr_mode_e   mode_i,
  output logic [W-1:0] next_o
);

  // select feedback structure by mode
  always_comb begin
    next_o = {state_i[W-2:0], ^(state_i & TAPS)};
    if (mode_i == MODE_GAL) begin
      next_o = {state_i[W-2:0], 1'b0}
             ^ ({W{state_i[W-1]}} & POLY);
    end
  end

endmodule

// File: rtl/sc_reg_lfsr.sv
// sc_reg_lfsr: LFSR random source with step/run/burst.
// Holds the FSM, burst counter, seed reference and flags.
module sc_reg_lfsr
  import sc_reg_lfsr_pkg::*;
#(
  parameter int RegLFSR_DATAWIDTH = 8,
  parameter logic [RegLFSR_DATAWIDTH-1:0] RegLFSR_TAPS = 8'hB8,
  parameter logic [RegLFSR_DATAWIDTH-1:0] RegLFSR_POLY = 8'h1D,
  parameter logic [RegLFSR_DATAWIDTH-1:0] RegLFSR_SEED = 8'h01
) (
  input  logic                         SC_RegLFSR_CLOCK_50,
  input  logic                         SC_RegLFSR_RESET_InLow,
  input  logic [RegLFSR_DATAWIDTH-1:0] SC_RegLFSR_seed_InBUS,
  input  logic                         SC_RegLFSR_load_In,
  input  logic                         SC_RegLFSR_mode_In,
  input  logic                         SC_RegLFSR_step_In,
  input  logic                         SC_RegLFSR_run_In,
  input  logic                         SC_RegLFSR_burstStart_In,
  input  logic [7:0]                   SC_RegLFSR_burstLen_InBUS,
  output logic [RegLFSR_DATAWIDTH-1:0] SC_RegLFSR_data_OutBUS,
  output logic                         SC_RegLFSR_valid_Out,
  output logic                         SC_RegLFSR_busy_Out,
  output logic                         SC_RegLFSR_done_Out,
  output logic                         SC_RegLFSR_zeroSeed_Out,
  output logic                         SC_RegLFSR_period_Out
);

  localparam int W = RegLFSR_DATAWIDTH;

  lfsr_state_e fsm_q, fsm_d;
  lfsr_mode_e  mode_q, mode_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] ref_q, ref_d;
  logic [W-1:0] next_w;
  logic [W-1:0] load_val;
  logic [7:0]   cnt_q, cnt_d;
  logic valid_q, valid_d;
  logic done_q, done_d;
  logic zero_q, zero_d;
  logic period_q, period_d;
  logic do_step;

  sc_lfsr_next #(
    .W    (W),
    .TAPS (RegLFSR_TAPS),
    .POLY (RegLFSR_POLY)
  ) u_next (
    .state_i (data_q),
    .mode_i  (mode_q),
    .next_o  (next_w)
  );

  // FSM, load/step decisions and flag next-values
  always_comb begin
    fsm_d    = fsm_q;
    mode_d   = mode_q;
    data_d   = data_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    do_step  = 1'b0;
    load_val = SC_RegLFSR_seed_InBUS;
    if (SC_RegLFSR_seed_InBUS == '0) begin
      load_val = RegLFSR_SEED;
    end
    if (SC_RegLFSR_load_In) begin
      fsm_d  = ST_IDLE;
      cnt_d  = 8'd0;
      data_d = load_val;
      ref_d  = load_val;
      mode_d = lfsr_mode_e'(SC_RegLFSR_mode_In);
      zero_d = (SC_RegLFSR_seed_InBUS == '0);
    end else begin
      unique case (fsm_q)
        ST_IDLE: begin
          if (SC_RegLFSR_burstStart_In) begin
            cnt_d = SC_RegLFSR_burstLen_InBUS;
            if (SC_RegLFSR_burstLen_InBUS == 8'd0) begin
              done_d = 1'b1;
            end else begin
              fsm_d = ST_BURST;
            end
          end else if (SC_RegLFSR_step_In || SC_RegLFSR_run_In) begin
            do_step = 1'b1;
          end
        end
        ST_BURST: begin
          do_step = 1'b1;
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            fsm_d  = ST_IDLE;
            done_d = 1'b1;
          end
        end
        default: fsm_d = ST_IDLE;
      endcase
    end
    if (do_step) begin
      data_d = next_w;
    end
    valid_d  = do_step;
    period_d = do_step && (next_w == ref_q);
  end

  // state and flag registers, async active-low reset
  always_ff @(posedge SC_RegLFSR_CLOCK_50 or negedge SC_RegLFSR_RESET_InLow) begin
    if (!SC_RegLFSR_RESET_InLow) begin
      fsm_q    <= ST_IDLE;
      mode_q   <= MODE_FIB;
      data_q   <= RegLFSR_SEED;
      ref_q    <= RegLFSR_SEED;
      cnt_q    <= 8'd0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      period_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      period_q <= period_d;
    end
  end

  assign SC_RegLFSR_data_OutBUS  = data_q;
  assign SC_RegLFSR_valid_Out    = valid_q;
  assign SC_RegLFSR_busy_Out     = (fsm_q == ST_BURST);
  assign SC_RegLFSR_done_Out     = done_q;
  assign SC_RegLFSR_zeroSeed_Out = zero_q;
  assign SC_RegLFSR_period_Out   = period_q;

endmodule

// File: tb/tb_sc_reg_lfsr.sv
// tb_sc_reg_lfsr: directed self-checking bench.
// Hand-computed vectors for step, run, burst, seed and period.
module tb_sc_reg_lfsr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] seed;
  logic       load, mode, step, run, bstart;
  logic [7:0] blen;
  logic [7:0] data;
  logic       valid, busy, done, zseed, period;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sc_reg_lfsr dut (
    .SC_RegLFSR_CLOCK_50       (clk),
    .SC_RegLFSR_RESET_InLow    (rst_n),
    .SC_RegLFSR_seed_InBUS     (seed),
    .SC_RegLFSR_load_In        (load),
    .SC_RegLFSR_mode_In        (mode),
    .SC_RegLFSR_step_In        (step),
    .SC_RegLFSR_run_In         (run),
    .SC_RegLFSR_burstStart_In  (bstart),
    .SC_RegLFSR_burstLen_InBUS (blen),
    .SC_RegLFSR_data_OutBUS    (data),
    .SC_RegLFSR_valid_Out      (valid),
    .SC_RegLFSR_busy_Out       (busy),
    .SC_RegLFSR_done_Out       (done),
    .SC_RegLFSR_zeroSeed_Out   (zseed),
    .SC_RegLFSR_period_Out     (period)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] s, input logic m);
    seed = s; mode = m; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  logic [7:0] fib_exp [6];
  logic [7:0] gal_exp [3];
  logic [7:0] bst_exp [4];
  int pulses;
  int pulse_at;
  logic run_valid_ok;

  initial begin
    fib_exp = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
    gal_exp = '{8'h80, 8'h1D, 8'h3A};
    bst_exp = '{8'h02, 8'h04, 8'h08, 8'h11};
    rst_n = 1'b0; seed = '0; load = 0; mode = 0;
    step = 0; run = 0; bstart = 0; blen = '0;
    #12;
    check("rst_data", data, 8'h01);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_zero", zseed, 0);
    check("rst_period", period, 0);
    rst_n = 1'b1;
    tick();

    do_load(8'h01, 1'b0);
    check("fib_load", data, 8'h01);
    check("fib_load_valid", valid, 0);
    for (int i = 0; i < 6; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      check("fib_data", data, fib_exp[i]);
      check("fib_valid", valid, 1);
      tick();
      check("fib_valid_low", valid, 0);
    end

    do_load(8'h40, 1'b1);
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gal_data", data, gal_exp[i]);
      check("gal_valid", valid, 1);
    end
    run = 1'b0;
    tick();
    check("gal_hold", data, 8'h3A);
    check("gal_valid_low", valid, 0);

    do_load(8'h01, 1'b0);
    bstart = 1'b1; blen = 8'd4;
    tick();
    bstart = 1'b0;
    check("bst_busy0", busy, 1);
    check("bst_nostep0", data, 8'h01);
    check("bst_valid0", valid, 0);
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) step = 1'b1;
      tick();
      step = 1'b0;
      check("bst_data", data, bst_exp[k-1]);
      check("bst_valid", valid, 1);
      check("bst_busy", busy, (k < 4) ? 1 : 0);
      check("bst_done", done, (k == 4) ? 1 : 0);
    end
    tick();
    check("bst_end_data", data, 8'h11);
    check("bst_end_done", done, 0);
    check("bst_end_valid", valid, 0);

    bstart = 1'b1; blen = 8'd0;
    tick();
    bstart = 1'b0;
    check("bz_busy", busy, 0);
    check("bz_done", done, 1);
    check("bz_data", data, 8'h11);
    tick();
    check("bz_done_low", done, 0);

    do_load(8'h00, 1'b0);
    check("zs_data", data, 8'h01);
    check("zs_flag", zseed, 1);
    do_load(8'h05, 1'b0);
    check("zs_data2", data, 8'h05);
    check("zs_clear", zseed, 0);

    do_load(8'h01, 1'b0);
    pulses = 0; pulse_at = 0; run_valid_ok = 1'b1;
    run = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (valid !== 1'b1) run_valid_ok = 1'b0;
      if (period === 1'b1) begin
        pulses++;
        pulse_at = k;
      end
    end
    run = 1'b0;
    check("per_data", data, 8'h01);
    check("per_count", pulses, 1);
    check("per_step", pulse_at, 255);
    check("per_valid", run_valid_ok, 1);
    tick();
    check("per_low", period, 0);

    do_load(8'h01, 1'b0);
    bstart = 1'b1; blen = 8'd10;
    tick();
    bstart = 1'b0;
    tick();
    tick();
    check("ab_mid", data, 8'h04);
    seed = 8'h5A; load = 1'b1;
    tick();
    load = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_data", data, 8'h5A);
    check("ab_done", done, 0);
    tick();
    check("ab_done2", done, 0);
    check("ab_data2", data, 8'h5A);

    bstart = 1'b1; blen = 8'd10;
    tick();
    bstart = 1'b0;
    tick();
    check("rb_busy", busy, 1);
    check("rb_valid", valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rb_data", data, 8'h01);
    check("rb_busy0", busy, 0);
    check("rb_valid0", valid, 0);
    check("rb_done0", done, 0);
    check("rb_zero0", zseed, 0);
    check("rb_period0", period, 0);
    #3 rst_n = 1'b1;
    tick();
    check("rb_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_reg_lfsr.md
# sc_reg_lfsr

Parametrised pseudo-random sequence generator: a width-configurable linear-feedback shift register with selectable Fibonacci or Galois feedback, seed loading, single-step, free-run and counted-burst operation. It replaces the fixed 8-bit shifter as the random-value source for game and test logic in the design. It also flags a zero-seed substitution and sequence wrap-around.

## Interface
- RegLFSR_DATAWIDTH, 8, register width W (4..32)
- RegLFSR_TAPS, 8'hB8, Fibonacci tap mask, bit i set means state[i] feeds the XOR
- RegLFSR_POLY, 8'h1D, Galois polynomial without the x^W term, bit i = coefficient of x^i
- RegLFSR_SEED, 8'h01, reset value and zero-seed substitute (must be non-zero)

Ports:
- SC_RegLFSR_CLOCK_50  in  1  clock, rising edge
- SC_RegLFSR_RESET_InLow  in  1  reset, asynchronous, active-low
- SC_RegLFSR_seed_InBUS  in  W  seed value
- SC_RegLFSR_load_In  in  1  load seed and latch mode, active-high
- SC_RegLFSR_mode_In  in  1  0 = Fibonacci, 1 = Galois; sampled only on load
- SC_RegLFSR_step_In  in  1  advance one step
- SC_RegLFSR_run_In  in  1  level: advance every cycle while high
- SC_RegLFSR_burstStart_In  in  1  start a counted burst
- SC_RegLFSR_burstLen_InBUS  in  8  burst step count, sampled on start
- SC_RegLFSR_data_OutBUS  out  W  current LFSR state, registered
- SC_RegLFSR_valid_Out  out  1  high the cycle after each step
- SC_RegLFSR_busy_Out  out  1  burst in progress
- SC_RegLFSR_done_Out  out  1  one-cycle pulse at burst end
- SC_RegLFSR_zeroSeed_Out  out  1  sticky: last load was zero and was substituted
- SC_RegLFSR_period_Out  out  1  one-cycle pulse when state returns to the last loaded seed

## Operation
- Fibonacci step: next = {state[W-2:0], ^(state & TAPS)}.
- Galois step: next = {state[W-2:0],1'b0} ^ ({W{state[W-1]}} & POLY).
- Load:
  - state <= seed, or SEED if seed == 0; in that case zeroSeed <= 1, otherwise zeroSeed <= 0.
  - Mode latch <= mode_In.
  - The loaded value is stored as the reference for period detection.
- FSM states: IDLE and BURST.
  - IDLE: burstStart sets cnt <= burstLen and moves to BURST, with no step that cycle. If burstLen == 0, stay in IDLE and pulse done the next cycle with no step. Otherwise step if step_In or run_In is high; both high gives one step.
  - BURST: step every cycle and decrement cnt. When cnt == 1, step, return to IDLE and set done <= 1.
  - step_In, run_In and burstStart are ignored while in BURST.
- Priority in every state: reset > load > burstStart > step/run.
  - Load in BURST aborts the burst: go to IDLE with no done pulse, and the load completes normally.
- period pulses the cycle after any step whose next state equals the stored reference.
- Mode changes without a load have no effect.

## Timing
- Reset values:
  - data = SEED, mode latch = Fibonacci, reference = SEED, FSM = IDLE, cnt = 0.
  - valid, busy, done, zeroSeed and period all 0.
- Step latency: new data is visible after the sampling edge; valid is high for that same following cycle.
- Load: data is updated after the edge; valid is not asserted.
- Burst of N: start sampled at edge 0, steps occur on edges 1..N.
  - busy is high after edge 0 until edge N.
  - done and the last valid are high together in the cycle after edge N, with busy already low.
- run_In held high: valid stays high continuously.
- Reset asserted mid-burst clears all outputs immediately, asynchronously.

## Structure
- Shared package/include holds the FSM state encodings (IDLE/BURST), the mode encodings and the default TAPS/POLY/SEED constants for W = 8, 16 and 32.
- Sub-module sc_lfsr_next is the combinational next-state function (state, mode → next), instantiated once.
- The top level holds the FSM, burst counter, seed reference and flags.

## Test plan
- Reset, then load 8'h01 in Fibonacci mode and pulse step 6 times → data 02, 04, 08, 11, 23, 47, with valid high exactly one cycle after each step.
- Load 8'h40 in Galois mode and hold run_In 3 cycles → data 80, 1D, 3A; valid stays high for 3 cycles.
- Load 8'h01 in Fibonacci mode, burstStart with len 4, step_In pulsed mid-burst → exactly 4 steps ending at 11; busy high for 4 cycles; done pulses once together with the last valid.
- Load 8'h00 → data = 01 and zeroSeed = 1; a following load of 8'h05 clears zeroSeed.
- Load 8'h01 in Fibonacci mode and run 255 steps → period pulses on the 255th step with data = 01; no earlier pulse.
- Start a burst of 10, assert load 8'h5A at step 3 → busy drops, no done pulse, data = 5A. Separately, assert reset mid-burst → all outputs return to their reset values asynchronously.
